pipe_hazard_ctrl: RTL

Parametrised hazard, forwarding and flush controller for the buffered five-stage processor datapath. It sits beside the decode stage and tracks every in-flight instruction downstream of decode in an internal scoreboard. From that scoreboard it drives the PC/IF-ID stall, the bubble into the ID/EX buffer, the forwarding selects for both ALU operands and the branch-squash flushes. It also keeps saturating stall and flush event counters for performance measurement.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/sat_counter.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register addresses are zero-extended to MAX_AW bits inside the scoreboard.
package pipe_pkg;

  localparam int MAX_AW = 8;
  localparam int FWD_RF = 0;
  localparam logic [MAX_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] dst;
    logic              regwrite;
    logic              load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // Register 0 is hard-wired zero, so it never counts as a produced value.
  function automatic logic writes_reg(sb_entry_t e, logic [MAX_AW-1:0] r);
    return e.valid && e.regwrite && (e.dst == r) && (r != ZERO_REG);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and branch-flush controller for a buffered five-stage datapath.
// A scoreboard mirrors every instruction between EX and WB.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int BR_STAGE = 2,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs,
  input  logic [REG_AW-1:0]        id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic [REG_AW-1:0]        id_dst,
  input  logic                     id_regwrite,
  input  logic                     id_load,
  input  logic                     br_taken,
  output logic                     stall,
  output logic                     bubble,
  output logic                     flush_if_id,
  output logic [DEPTH-1:0]         flush_mask,
  output logic [$clog2(DEPTH)-1:0] fwd_a,
  output logic [$clog2(DEPTH)-1:0] fwd_b,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int FW = $clog2(DEPTH);
  localparam logic [DEPTH-1:0] BR_MASK = DEPTH'((1 << BR_STAGE) - 1);

  sb_entry_t         sb [DEPTH];
  logic [MAX_AW-1:0] s0_rs, s0_rt;
  logic              s0_use_rs, s0_use_rt;

  logic [MAX_AW-1:0] rs_x, rt_x, dst_x;
  logic              hazard;
  logic              issue;

  assign rs_x  = MAX_AW'(id_rs);
  assign rt_x  = MAX_AW'(id_rt);
  assign dst_x = MAX_AW'(id_dst);

  // With forwarding only a load still in EX blocks; without it every producer does.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((FWD_EN == 0 || (k == 0 && sb[k].load)) &&
          ((id_use_rs && writes_reg(sb[k], rs_x)) ||
           (id_use_rt && writes_reg(sb[k], rt_x))))
        hazard = 1'b1;
    end
  end

  assign stall       = id_valid & hazard & ~br_taken;
  assign bubble      = stall;
  assign issue       = id_valid & ~stall & ~br_taken;
  assign flush_if_id = br_taken;
  assign flush_mask  = br_taken ? BR_MASK : '0;

  // Walk from the oldest stage down so the youngest producer wins; a load in
  // stage 1 is skipped because the load-use stall already separated it.
  always_comb begin
    fwd_a = FW'(FWD_RF);
    fwd_b = FW'(FWD_RF);
    if (FWD_EN != 0) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (!(k == 1 && sb[k].load)) begin
          if (s0_use_rs && writes_reg(sb[k], s0_rs)) fwd_a = FW'(k);
          if (s0_use_rt && writes_reg(sb[k], s0_rt)) fwd_b = FW'(k);
        end
      end
    end
  end

  // NOTE: the scoreboard is a handful of flops, so every entry is reset, not just valid.
  // NOTE: state uses non-blocking assignments so all stages shift off the same old values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= SB_EMPTY;
      s0_rs     <= ZERO_REG;
      s0_rt     <= ZERO_REG;
      s0_use_rs <= 1'b0;
      s0_use_rt <= 1'b0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--)
        sb[k] <= (br_taken && (k - 1) < BR_STAGE) ? SB_EMPTY : sb[k-1];
      if (issue) begin
        sb[0]     <= '{valid: 1'b1, dst: dst_x, regwrite: id_regwrite, load: id_load};
        s0_rs     <= rs_x;
        s0_rt     <= rt_x;
        s0_use_rs <= id_use_rs;
        s0_use_rt <= id_use_rt;
      end else begin
        sb[0]     <= SB_EMPTY;
        s0_rs     <= ZERO_REG;
        s0_rt     <= ZERO_REG;
        s0_use_rs <= 1'b0;
        s0_use_rt <= 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (br_taken),
    .count (flush_cnt)
  );

endmodule
